fir_param: RTL

- Parametrised direct-form FIR filter with N taps and W-bit signed fractional (Q1.W-1) data and coefficients.
- Coefficients are held in a runtime-writable register bank instead of static coefficient ports.
- It has a pipelined multiply/add datapath with valid propagation and output saturation.
- It drops into the FIR test bench between the sample source and the data sink, using the same VIN/VOUT sample-valid convention.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_sat.sv | 30 +++
 rtl/fir_param.sv | 100 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared arithmetic helpers for the fixed-point filter family (FIR now, IIR later).
// Every width and bound is derived from the sample width W and the tap count N.
package fir_pkg;

    // Accumulator width: full product width plus headroom for summing N products
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

    // Shift that brings a Q2.(2W-2) product sum back to Q1.(W-1)
    function automatic int q_shift(input int w);
        return w - 1;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_sat.sv
// Combinational truncate-and-saturate from accumulator width down to W bits.
// The shift is arithmetic, so results are floored (truncated toward minus infinity).
module fir_sat
    import fir_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 34
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [W-1:0]     sat_out
);

    localparam int QS = q_shift(W);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(W));

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> QS;
        if (shifted > SAT_HI) begin
            sat_out = SAT_HI[W-1:0];
        end else if (shifted < SAT_LO) begin
            sat_out = SAT_LO[W-1:0];
        end else begin
            sat_out = shifted[W-1:0];
        end
    end

endmodule

// File: rtl/fir_param.sv
// N-tap direct-form FIR with a runtime-writable coefficient bank.
// Two-stage pipeline: products at the first edge after capture, saturated sum at the second.
module fir_param
    import fir_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 16,
    localparam int AW = $clog2(N)
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic signed [W-1:0] DIN,
    input  logic                VIN,
    input  logic                COEF_WE,
    input  logic [AW-1:0]       COEF_ADDR,
    input  logic signed [W-1:0] COEF_DATA,
    output logic signed [W-1:0] DOUT,
    output logic                VOUT
);

    localparam int ACC_W = acc_width(W, N);

    logic signed [W-1:0]     x    [N];
    logic signed [W-1:0]     coef [N];
    logic signed [2*W-1:0]   prod [N];
    logic                    x_valid;
    logic                    prod_valid;
    logic signed [ACC_W-1:0] acc;
    logic signed [W-1:0]     sat_out;

    // Delay line only advances on accepted samples, so idle cycles never inject zeros
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int k = 0; k < N; k++) begin
                x[k] <= '0;
            end
        end else if (VIN) begin
            x[0] <= DIN;
            for (int k = 1; k < N; k++) begin
                x[k] <= x[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int k = 0; k < N; k++) begin
                coef[k] <= '0;
            end
        end else if (COEF_WE && (int'(COEF_ADDR) < N)) begin
            coef[COEF_ADDR] <= COEF_DATA;
        end
    end

    // Products are recomputed every edge; a same-edge coefficient write is seen by the next sample
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int k = 0; k < N; k++) begin
                prod[k] <= '0;
            end
            x_valid    <= 1'b0;
            prod_valid <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                prod[k] <= coef[k] * x[k];
            end
            x_valid    <= VIN;
            prod_valid <= x_valid;
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + ACC_W'(prod[k]);
        end
    end

    fir_sat #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_sat (
        .acc     (acc),
        .sat_out (sat_out)
    );

    // DOUT only moves on a valid result, so it holds between output pulses
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            DOUT <= '0;
            VOUT <= 1'b0;
        end else begin
            VOUT <= prod_valid;
            if (prod_valid) begin
                DOUT <= sat_out;
            end
        end
    end

endmodule
